// File: rtl/encoder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// encoder_ctrl_pkg
// Shared definitions for the encoder sampling controller:
//   - ctrl_state_e    : controller FSM states (IDLE, RUN, CLEAR1, CLEAR2)
//   - COUNT_W_DEFAULT : default width of encoder count / position / delta
//   - TS_W            : width of the optional capture timestamp
//   - zero_allowed()  : states in which a zero request is honoured
// ---------------------------------------------------------------------------
package encoder_ctrl_pkg;

    localparam int COUNT_W_DEFAULT = 32;
    localparam int TS_W            = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        CLEAR1 = 2'd2,
        CLEAR2 = 2'd3
    } ctrl_state_e;

    // Zeroing may only start from a quiescent or sampling state; a request
    // arriving while a clear is already in flight is dropped.
    function automatic logic zero_allowed(input ctrl_state_e s);
        return (s == IDLE) || (s == RUN);
    endfunction

endpackage

// File: rtl/sample_period_timer.sv
// ---------------------------------------------------------------------------
// sample_period_timer
// Counts 0 .. PERIOD-1 while run_i is high and wraps to 0, emitting a one-cycle
// terminal pulse on the PERIOD-1 cycle. restart_i synchronously forces the
// count to 0 and has priority over run_i (no terminal pulse while restarting).
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   run_i      in   count enable
//   restart_i  in   synchronous restart to 0
//   terminal_o out  high in the cycle the count equals PERIOD-1
// ---------------------------------------------------------------------------
module sample_period_timer #(
    parameter int PERIOD   = 1000,
    parameter int PERIOD_W = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    input  logic restart_i,
    output logic terminal_o
);

    localparam logic [PERIOD_W-1:0] LAST = PERIOD_W'(PERIOD - 1);

    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] timer_d;
    logic                at_last;

    assign at_last    = (timer_q == LAST);
    assign terminal_o = run_i && !restart_i && at_last;

    always_comb begin
        timer_d = timer_q;
        if (restart_i) begin
            timer_d = '0;
        end else if (run_i) begin
            timer_d = at_last ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/encoder_sample_ctrl.sv
// ---------------------------------------------------------------------------
// encoder_sample_ctrl
// Periodic sampling controller for a quadrature encoder counter. Every PERIOD
// cycles in RUN it snapshots count_in and computes the modulo-2^COUNT_W delta
// since the last delivered sample, presenting both on a valid/ready output.
// A capture that finds the output register occupied is dropped and sets the
// sticky overrun flag; prev is then left alone so the next delivered delta
// covers every elapsed period. zero_req sequences a one-cycle enc_clear pulse
// followed by a settle cycle, after which the delta reference is 0.
//
// Optional feature macro: ENC_TIMESTAMP_EN
//   defined   -> adds sample_ts (free-running cycle counter value at capture)
//   undefined -> no timestamp port or counter
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            level: 1 = sampling runs
//   count_in, dir_in  encoder count and direction
//   zero_req          single-cycle request to zero the encoder
//   enc_clear         active-high encoder reset output
//   sample_valid/ready, sample_pos/delta/dir   sample output handshake + data
//   overrun, overrun_clr                        sticky drop flag and its clear
//   sample_ts         (ENC_TIMESTAMP_EN only) capture timestamp
// ---------------------------------------------------------------------------
module encoder_sample_ctrl
    import encoder_ctrl_pkg::*;
#(
    parameter int COUNT_W  = COUNT_W_DEFAULT,
    parameter int PERIOD   = 1000,
    parameter int PERIOD_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               dir_in,
    input  logic               zero_req,
    output logic               enc_clear,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [COUNT_W-1:0] sample_pos,
    output logic [COUNT_W-1:0] sample_delta,
    output logic               sample_dir,
    output logic               overrun,
`ifdef ENC_TIMESTAMP_EN
    output logic [TS_W-1:0]    sample_ts,
`endif
    input  logic               overrun_clr
);

    ctrl_state_e        state_q, state_d;
    logic [COUNT_W-1:0] prev_q, prev_d;
    logic               valid_q, valid_d;
    logic [COUNT_W-1:0] pos_q, pos_d;
    logic [COUNT_W-1:0] delta_q, delta_d;
    logic               dir_q, dir_d;
    logic               overrun_q, overrun_d;

    logic timer_run;
    logic timer_restart;
    logic terminal;
    logic capture;
    logic out_free;
    logic capture_load;
    logic zero_go;

    sample_period_timer #(
        .PERIOD   (PERIOD),
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_i      (timer_run),
        .restart_i  (timer_restart),
        .terminal_o (terminal)
    );

    // The output register can take new data if empty or being drained this cycle.
    assign out_free     = !valid_q || sample_ready;
    assign capture_load = capture && out_free;
    assign zero_go      = zero_req && zero_allowed(state_q);

    // Next-state / control
    always_comb begin
        state_d       = state_q;
        timer_run     = 1'b0;
        timer_restart = 1'b0;
        capture       = 1'b0;
        prev_d        = prev_q;

        unique case (state_q)
            IDLE: begin
                timer_restart = 1'b1;
                if (zero_go) begin
                    state_d = CLEAR1;
                end else if (enable) begin
                    prev_d  = count_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Zeroing beats a terminal-cycle capture.
                if (zero_go) begin
                    timer_restart = 1'b1;
                    state_d       = CLEAR1;
                end else if (!enable) begin
                    timer_restart = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_run = 1'b1;
                    capture   = terminal;
                end
            end
            CLEAR1: begin
                timer_restart = 1'b1;
                state_d       = CLEAR2;
            end
            CLEAR2: begin
                timer_restart = 1'b1;
                prev_d        = '0;
                state_d       = enable ? RUN : IDLE;
            end
            default: begin
                timer_restart = 1'b1;
                state_d       = IDLE;
            end
        endcase

        // A dropped capture must not move prev, so the reference only
        // advances when the sample is actually loaded.
        if (capture_load) begin
            prev_d = count_in;
        end
    end

    // Output register and overrun flag
    always_comb begin
        valid_d   = valid_q;
        pos_d     = pos_q;
        delta_d   = delta_q;
        dir_d     = dir_q;
        overrun_d = overrun_q;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (capture_load) begin
            valid_d = 1'b1;
            pos_d   = count_in;
            delta_d = count_in - prev_q;
            dir_d   = dir_in;
        end else if (capture) begin
            overrun_d = 1'b1;   // set wins over a same-cycle clear
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            valid_q   <= 1'b0;
            pos_q     <= '0;
            delta_q   <= '0;
            dir_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            valid_q   <= valid_d;
            pos_q     <= pos_d;
            delta_q   <= delta_d;
            dir_q     <= dir_d;
            overrun_q <= overrun_d;
        end
    end

    // Decoded from the registered state so the pulse is exactly the CLEAR1
    // cycle and drops immediately on async reset.
    assign enc_clear    = (state_q == CLEAR1);
    assign sample_valid = valid_q;
    assign sample_pos   = pos_q;
    assign sample_delta = delta_q;
    assign sample_dir   = dir_q;
    assign overrun      = overrun_q;

`ifdef ENC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (capture_load) begin
                ts_q <= ts_cnt_q;
            end
        end
    end

    assign sample_ts = ts_q;
`endif

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_encoder_sample_ctrl
// Directed bench for encoder_sample_ctrl with PERIOD=4. Inputs change 1 ns
// after each rising edge; outputs are checked at the same point. count_in
// advances by 'inc' after every edge.
// ---------------------------------------------------------------------------
module tb_encoder_sample_ctrl;
    import encoder_ctrl_pkg::*;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] count_in;
    logic          dir_in;
    logic          zero_req;
    logic          enc_clear;
    logic          sample_valid;
    logic          sample_ready;
    logic [CW-1:0] sample_pos;
    logic [CW-1:0] sample_delta;
    logic          sample_dir;
    logic          overrun;
    logic          overrun_clr;
`ifdef ENC_TIMESTAMP_EN
    logic [TS_W-1:0] sample_ts;
    logic [TS_W-1:0] ts_first;
`endif

    int vectors    = 0;
    int miscompares = 0;
    logic [CW-1:0] inc;

    always #5 clk = ~clk;

    encoder_sample_ctrl #(
        .COUNT_W  (CW),
        .PERIOD   (4),
        .PERIOD_W (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .count_in     (count_in),
        .dir_in       (dir_in),
        .zero_req     (zero_req),
        .enc_clear    (enc_clear),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_pos   (sample_pos),
        .sample_delta (sample_delta),
        .sample_dir   (sample_dir),
        .overrun      (overrun),
`ifdef ENC_TIMESTAMP_EN
        .sample_ts    (sample_ts),
`endif
        .overrun_clr  (overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%08h exp=0x%08h", vectors, tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            count_in = count_in + inc;
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; count_in = '0; dir_in = 1'b0;
        zero_req = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0; inc = '0;
        tick(2);
        check("rst_valid",   32'(sample_valid), 32'd0);
        check("rst_pos",     sample_pos, 32'd0);
        check("rst_delta",   sample_delta, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_clear",   32'(enc_clear), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Basic sampling: RUN entry at E1 with count 100, captures at E5, E9
        count_in = 100; inc = 1; enable = 1'b1; sample_ready = 1'b1; dir_in = 1'b1;
        tick(4);                                      // after E4
        check("basic_pre_valid", 32'(sample_valid), 32'd0);
        tick(1);                                      // E5
        check("basic_valid1", 32'(sample_valid), 32'd1);
        check("basic_pos1",   sample_pos, 32'd104);
        check("basic_delta1", sample_delta, 32'd4);
        check("basic_dir1",   32'(sample_dir), 32'd1);
        tick(1);                                      // E6 transfer
        check("basic_drop", 32'(sample_valid), 32'd0);

        // Backpressure: E9 loads, E13 is dropped
        sample_ready = 1'b0;
        tick(3);                                      // E9
        check("bp_valid", 32'(sample_valid), 32'd1);
        check("bp_pos",   sample_pos, 32'd108);
        check("bp_delta", sample_delta, 32'd4);
        tick(4);                                      // E13 drop
        check("bp_overrun",  32'(overrun), 32'd1);
        check("bp_pos_hold", sample_pos, 32'd108);
        check("bp_delta_hold", sample_delta, 32'd4);
        sample_ready = 1'b1;
        tick(1);                                      // E14 transfer
        check("bp_xfer", 32'(sample_valid), 32'd0);
        tick(3);                                      // E17 capture 116
        check("bp_valid2", 32'(sample_valid), 32'd1);
        check("bp_pos2",   sample_pos, 32'd116);
        check("bp_delta2", sample_delta, 32'd8);
        overrun_clr = 1'b1;
        tick(1);                                      // E18
        overrun_clr = 1'b0;
        check("bp_clr", 32'(overrun), 32'd0);

        // Wrap-around upward
        enable = 1'b0;
        tick(1);                                      // E19 -> IDLE
        count_in = 32'hFFFF_FFFE; enable = 1'b1;
        tick(5);                                      // E20 entry .. E24 capture
        check("wrap_valid", 32'(sample_valid), 32'd1);
        check("wrap_pos",   sample_pos, 32'h0000_0002);
        check("wrap_delta", sample_delta, 32'h0000_0004);

        // Decreasing count 10 -> 7
        enable = 1'b0;
        tick(1);                                      // E25 -> IDLE, transfer
        count_in = 10; inc = '0; dir_in = 1'b0; enable = 1'b1;
        tick(1);                                      // E26 entry, prev=10
        count_in = 7;
        tick(4);                                      // E30 capture
        check("dec_valid", 32'(sample_valid), 32'd1);
        check("dec_delta", sample_delta, 32'hFFFF_FFFD);
        check("dec_dir",   32'(sample_dir), 32'd0);

        // Zero request in the terminal cycle (E34)
        tick(3);                                      // E31 transfer, E32, E33
        check("zero_pre_valid", 32'(sample_valid), 32'd0);
        zero_req = 1'b1;
        tick(1);                                      // E34 -> CLEAR1
        zero_req = 1'b0;
        check("zero_clear_hi",  32'(enc_clear), 32'd1);
        check("zero_no_capture", 32'(sample_valid), 32'd0);
        check("zero_no_overrun", 32'(overrun), 32'd0);
        tick(1);                                      // E35 -> CLEAR2
        check("zero_clear_lo", 32'(enc_clear), 32'd0);
        count_in = 20;
        tick(2);                                      // E36 -> RUN, E37
        check("zero_wait_valid", 32'(sample_valid), 32'd0);
        tick(3);                                      // E40 capture
        check("zero_valid", 32'(sample_valid), 32'd1);
        check("zero_delta", sample_delta, 32'd20);

        // Overrun set and clear in the same cycle, then async reset mid-handshake
        sample_ready = 1'b0;
        tick(3);                                      // E43
        overrun_clr = 1'b1;
        tick(1);                                      // E44 drop + clr
        overrun_clr = 1'b0;
        check("setwins_overrun", 32'(overrun), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("areset_valid",   32'(sample_valid), 32'd0);
        check("areset_overrun", 32'(overrun), 32'd0);
        check("areset_clear",   32'(enc_clear), 32'd0);
        check("areset_pos",     sample_pos, 32'd0);
        tick(1);                                      // E45 in reset
        count_in = 1000; inc = 3; sample_ready = 1'b1; reset_n = 1'b1;
        tick(5);                                      // E46 entry .. E50 capture
        check("post_rst_valid", 32'(sample_valid), 32'd1);
        check("post_rst_delta", sample_delta, 32'd12);
        check("post_rst_pos",   sample_pos, 32'd1012);
`ifdef ENC_TIMESTAMP_EN
        ts_first = sample_ts;
`endif
        tick(4);                                      // E54 capture
        check("next_delta", sample_delta, 32'd12);
`ifdef ENC_TIMESTAMP_EN
        check("ts_step", sample_ts - ts_first, 32'd4);
`endif

        // Async reset while enc_clear is high
        zero_req = 1'b1;
        tick(1);                                      // E55 -> CLEAR1
        zero_req = 1'b0;
        check("clr_mid_hi", 32'(enc_clear), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("clr_mid_rst", 32'(enc_clear), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        check("clr_mid_after", 32'(enc_clear), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
